// File: rtl/stream_arb_pkg.sv
// Shared types and width helpers for the stream round-robin arbiter.
package stream_arb_pkg;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StBusy = 1'b1
  } arb_state_e;

  // Requester index width; never narrower than one bit.
  function automatic int unsigned id_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or above rr_ptr, wrapping around.
module rr_pick
  import stream_arb_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = id_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  rr_ptr,
  output logic             any,
  output logic [ID_W-1:0]  idx
);

  logic [2*N_REQ-1:0] w_dbl;
  logic [N_REQ-1:0]   w_rot;

  // Bit k of w_rot is requester (rr_ptr + k) mod N_REQ.
  assign w_dbl = {req, req} >> rr_ptr;
  assign w_rot = w_dbl[N_REQ-1:0];
  assign any   = |req;

  always_comb begin
    int v_sum;
    v_sum = 0;
    idx   = '0;
    // Walk downward so the lowest rotated offset wins.
    for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        v_sum = int'(rr_ptr) + k;
      end
    end
    if (v_sum >= int'(N_REQ)) begin
      v_sum = v_sum - int'(N_REQ);
    end
    idx = ID_W'(v_sum);
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin burst arbiter merging N_REQ valid/ready streams into one registered stream.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter  int unsigned DATA_W    = 8,
  parameter  int unsigned N_REQ     = 4,
  parameter  int unsigned MAX_BURST = 4,
  localparam int unsigned ID_W      = id_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ*DATA_W-1:0] in_data,
  input  logic [N_REQ-1:0]        in_valid,
  input  logic [N_REQ-1:0]        in_last,
  output logic [N_REQ-1:0]        in_ready,
  output logic [DATA_W-1:0]       out_data,
  output logic [ID_W-1:0]         out_id,
  output logic                    out_valid,
  input  logic                    out_ready
);

  arb_state_e        r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_grant;
  logic [7:0]        r_beat_cnt;
  logic              r_out_valid;
  logic [DATA_W-1:0] r_out_data;
  logic [ID_W-1:0]   r_out_id;

  logic [N_REQ-1:0][DATA_W-1:0] w_data_arr;
  logic                         w_pick_any;
  logic [ID_W-1:0]              w_pick_idx;
  logic                         w_busy;
  logic                         w_sel_valid;
  logic                         w_sel_last;
  logic                         w_slot_free;
  logic                         w_accept;
  logic [7:0]                   w_cnt_next;
  logic                         w_burst_full;
  logic                         w_release;
  logic [ID_W-1:0]              w_next_ptr;

  rr_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_rr_pick (
    .req    (in_valid),
    .rr_ptr (r_rr_ptr),
    .any    (w_pick_any),
    .idx    (w_pick_idx)
  );

  assign w_data_arr   = in_data;
  assign w_busy       = (r_state == StBusy);
  assign w_sel_valid  = in_valid[r_grant];
  assign w_sel_last   = in_last[r_grant];
  assign w_slot_free  = !r_out_valid || out_ready;
  assign w_accept     = w_busy && w_sel_valid && w_slot_free;
  assign w_cnt_next   = r_beat_cnt + 8'd1;
  assign w_burst_full = (w_cnt_next == 8'(MAX_BURST));
  // Any one of the three causes ends the grant; they collapse into one release.
  assign w_release    = w_busy && (!w_sel_valid || (w_accept && (w_sel_last || w_burst_full)));
  assign w_next_ptr   = (r_grant == ID_W'(N_REQ - 1)) ? '0 : r_grant + 1'b1;

  always_comb begin
    in_ready = '0;
    if (w_busy) begin
      in_ready[r_grant] = w_slot_free;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= StIdle;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_pick_any) begin
            r_grant    <= w_pick_idx;
            r_beat_cnt <= '0;
            r_state    <= StBusy;
          end
        end
        StBusy: begin
          if (w_accept) begin
            r_beat_cnt <= w_cnt_next;
          end
          if (w_release) begin
            r_rr_ptr <= w_next_ptr;
            r_state  <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_data_arr[r_grant];
      r_out_id    <= r_grant;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Scenario bench for stream_rr_arbiter with per-requester scoreboard behind a 16-deep FIFO model.
module tb_stream_rr_arbiter;

  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [NR*DW-1:0] in_data = '0;
  logic [NR-1:0]    in_valid = '0;
  logic [NR-1:0]    in_last = '0;
  logic [NR-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic [1:0]       out_id;
  logic             out_valid;
  logic             out_ready = 1'b1;

  stream_rr_arbiter #(
    .DATA_W    (DW),
    .N_REQ     (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q [NR][$];
  logic [9:0]  fifo_q[$];
  logic [NR-1:0] hs = '0;
  int seq    [NR];
  int cnt_hs [NR];
  int last_at[NR];
  bit rand_mode = 1'b0;
  int rd_prob   = 100;

  // Monitor: record handshakes as expectations, model the FIFO, compare at its read side.
  always @(negedge clk) begin
    logic [9:0] ent;
    logic [7:0] exp_d;
    int rid;
    ent = '0;
    exp_d = '0;
    rid = 0;
    if (!rst) begin
      hs = '0;
    end else begin
      if (fifo_q.size() > 0 && int'($urandom_range(0, 99)) < rd_prob) begin
        ent = fifo_q.pop_front();
        rid = int'(ent[9:8]);
        total++;
        if (exp_q[rid].size() == 0) begin
          bad++;
          $display("FAIL fifo_read id=%0d got=%02h required=<no pending beat>", rid, ent[7:0]);
        end else begin
          exp_d = exp_q[rid].pop_front();
          if (ent[7:0] !== exp_d) begin
            bad++;
            $display("FAIL fifo_read id=%0d got=%02h required=%02h", rid, ent[7:0], exp_d);
          end
        end
      end
      if (out_valid === 1'b1 && out_ready) fifo_q.push_back({out_id, out_data});
      for (int i = 0; i < NR; i++) begin
        hs[i] = in_valid[i] && in_ready[i];
        if (hs[i]) exp_q[i].push_back(in_data[i*DW +: DW]);
      end
    end
  end

  task automatic drive_data();
    for (int i = 0; i < NR; i++) in_data[i*DW +: DW] = 8'(i * 64 + seq[i] % 64);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) begin
      if (hs[i]) begin
        seq[i]++;
        cnt_hs[i]++;
      end
      if (rand_mode) begin
        if (!in_valid[i] || hs[i]) in_valid[i] = ($urandom_range(0, 99) < 60);
        else if ($urandom_range(0, 99) < 5) in_valid[i] = 1'b0;
        in_last[i] = ($urandom_range(0, 99) < 25);
      end else begin
        in_last[i] = (cnt_hs[i] == last_at[i]);
      end
    end
    drive_data();
    if (rand_mode) out_ready = (fifo_q.size() < 12) && ($urandom_range(0, 99) < 40);
  endtask

  task automatic flush_model();
    for (int i = 0; i < NR; i++) begin
      exp_q[i].delete();
      cnt_hs[i]  = 0;
      last_at[i] = -1;
    end
    fifo_q.delete();
    hs = '0;
  endtask

  task automatic do_reset();
    rst       = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    out_ready = 1'b1;
    rand_mode = 1'b0;
    rd_prob   = 100;
    flush_model();
    drive_data();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    bit found;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      in_valid  = 4'($urandom());
      in_last   = 4'($urandom());
      in_data   = $urandom();
      out_ready = 1'($urandom());
      @(negedge clk);
      total++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_id !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold got valid=%b ready=%b id=%0d required valid=0 ready=0000 id=0",
                 out_valid, in_ready, out_id);
      end
    end
    @(posedge clk);
    #1;
    flush_model();
    in_valid  = '1;
    in_last   = '0;
    out_ready = 1'b1;
    drive_data();
    rst = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      @(negedge clk);
      found = out_valid;
    end
    total++;
    if (!found || out_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_first_grant got valid=%b id=%0d required valid=1 id=0", found, out_id);
    end
  endtask

  task automatic test_reset_mid_burst();
    bit found;
    do_reset();
    in_valid = '1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      @(negedge clk);
      found = out_valid;
    end
    step();
    rst = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || in_ready !== 4'b0000 || out_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_async got valid=%b ready=%b id=%0d required valid=0 ready=0000 id=0",
               out_valid, in_ready, out_id);
    end
    flush_model();
    @(posedge clk);
    #1;
    rst = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      @(negedge clk);
      found = out_valid;
    end
    total++;
    if (!found || out_id !== 2'd0) begin
      bad++;
      $display("FAIL reset_mid_regrant got valid=%b id=%0d required valid=1 id=0", found, out_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_rr[21] = '{0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 2, 2, 2, 2, -1, 3, 3, 3, 3, -1, 0};
    int got;
    bit found;
    do_reset();
    in_valid = '1;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      @(negedge clk);
      found = out_valid;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL rr_start got out_valid=0 required out_valid=1 within 10 cycles");
    end
    for (int k = 0; k < 21; k++) begin
      if (k > 0) begin
        step();
        @(negedge clk);
      end
      got = out_valid ? int'(out_id) : -1;
      total++;
      if (got !== exp_rr[k]) begin
        bad++;
        $display("FAIL rr_order cycle=%0d got id=%0d required id=%0d (-1 = bubble)",
                 k, got, exp_rr[k]);
      end
    end
  endtask

  task automatic test_last();
    int ids[$];
    int exp_ids[3] = '{2, 2, 3};
    int got;
    bit switched;
    do_reset();
    last_at[2] = 1;
    in_valid = 4'b0100;
    switched = 1'b0;
    for (int c = 0; c < 30 && ids.size() < 3; c++) begin
      step();
      if (!switched && cnt_hs[2] == 2) begin
        in_valid = 4'b1001;
        switched = 1'b1;
        @(negedge clk);
        total++;
        if (in_ready !== 4'b0000) begin
          bad++;
          $display("FAIL last_idle_ready got=%b required=0000", in_ready);
        end
      end else begin
        @(negedge clk);
      end
      if (out_valid && out_ready) ids.push_back(int'(out_id));
    end
    for (int k = 0; k < 3; k++) begin
      got = (k < ids.size()) ? ids[k] : -1;
      total++;
      if (got !== exp_ids[k]) begin
        bad++;
        $display("FAIL last_ids beat=%0d got id=%0d required id=%0d", k, got, exp_ids[k]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [7:0] exp_hold;
    bit found;
    do_reset();
    in_valid = 4'b0001;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      step();
      @(negedge clk);
      found = out_valid;
    end
    step();
    exp_hold = (exp_q[0].size() > 0) ? exp_q[0][$] : 8'hxx;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++;
      if (out_valid !== 1'b1 || out_data !== exp_hold || in_ready !== 4'b0000) begin
        bad++;
        $display("FAIL bp_hold cycle=%0d got valid=%b data=%02h ready=%b required 1/%02h/0000",
                 c, out_valid, out_data, in_ready, exp_hold);
      end
      step();
    end
    out_ready = 1'b1;
    repeat (10) step();
    in_valid = '0;
    repeat (20) step();
    for (int i = 0; i < NR; i++) begin
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL bp_lossless req=%0d got pending=%0d required 0", i, exp_q[i].size());
      end
    end
  endtask

  task automatic test_valid_drop();
    int ids[$];
    int exp_ids[2] = '{1, 3};
    int got;
    bit dropped;
    do_reset();
    in_valid = 4'b1010;
    dropped = 1'b0;
    for (int c = 0; c < 30 && ids.size() < 2; c++) begin
      step();
      if (!dropped && cnt_hs[1] == 1) begin
        in_valid[1] = 1'b0;
        dropped = 1'b1;
      end
      @(negedge clk);
      if (out_valid && out_ready) ids.push_back(int'(out_id));
    end
    for (int k = 0; k < 2; k++) begin
      got = (k < ids.size()) ? ids[k] : -1;
      total++;
      if (got !== exp_ids[k]) begin
        bad++;
        $display("FAIL drop_ids beat=%0d got id=%0d required id=%0d", k, got, exp_ids[k]);
      end
    end
  endtask

  task automatic test_random();
    int beats;
    do_reset();
    rand_mode = 1'b1;
    rd_prob   = 50;
    repeat (800) step();
    rand_mode = 1'b0;
    in_valid  = '0;
    out_ready = 1'b1;
    rd_prob   = 100;
    repeat (40) step();
    beats = 0;
    for (int i = 0; i < NR; i++) begin
      beats += cnt_hs[i];
      total++;
      if (exp_q[i].size() != 0) begin
        bad++;
        $display("FAIL rand_lossless req=%0d got pending=%0d required 0", i, exp_q[i].size());
      end
    end
    total++;
    if (fifo_q.size() != 0 || beats < 50) begin
      bad++;
      $display("FAIL rand_drain got fifo=%0d beats=%0d required fifo=0 beats>=50",
               fifo_q.size(), beats);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) begin
      seq[i]     = 0;
      cnt_hs[i]  = 0;
      last_at[i] = -1;
    end
    test_reset();
    test_reset_mid_burst();
    test_round_robin();
    test_last();
    test_back_pressure();
    test_valid_drop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/stream_rr_arbiter.md
STREAM_RR_ARBITER -- requirements
Module: stream_rr_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 8, payload width per requester.
REQ-002 SHALL have parameter N_REQ, default 4, number of requesters (2..16).
REQ-003 SHALL have parameter MAX_BURST, default 4, maximum beats per grant (1..255).
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset (asserted when 0).
REQ-006 SHALL have port in_data  input  N_REQ*DATA_W  requester payloads; requester i occupies bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port in_valid  input  N_REQ  per-requester valid.
REQ-008 SHALL have port in_last  input  N_REQ  per-requester end-of-burst marker, qualified by valid.
REQ-009 SHALL have port in_ready  output  N_REQ  per-requester ready.
REQ-010 SHALL have port out_data  output  DATA_W  registered payload toward the shared FIFO write side.
REQ-011 SHALL have port out_id  output  ID_W=max(1,clog2(N_REQ))  index of the requester that supplied out_data.
REQ-012 SHALL have port out_valid  output  1  registered valid toward the shared FIFO.
REQ-013 SHALL have port out_ready  input  1  FIFO write ready.

Function
REQ-014 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-015 In IDLE, if any in_valid is high, SHALL grant the first valid requester found scanning from rr_ptr upward with wrap-around, latch grant, clear beat_cnt, and enter BUSY next cycle; no beat is accepted in the IDLE cycle.
REQ-016 In IDLE, all in_ready SHALL be 0.
REQ-017 In BUSY, in_ready[grant] SHALL equal (!out_valid || out_ready); all other in_ready SHALL be 0.
REQ-018 An accepted beat (in_valid[grant] && in_ready[grant]) SHALL load out_data, out_id=grant, out_valid=1 on the next edge: latency one cycle, full throughput within a burst.
REQ-019 out_valid SHALL clear on an edge where out_ready=1 and no beat is accepted; out_data/out_id SHALL hold while out_valid=1 && out_ready=0.
REQ-020 beat_cnt SHALL increment on each accepted beat (8-bit counter).
REQ-021 Release SHALL occur when: accepted beat with in_last[grant]=1; or accepted beat makes beat_cnt reach MAX_BURST; or in_valid[grant]=0 in any BUSY cycle.
REQ-022 On release, SHALL set rr_ptr=(grant+1) mod N_REQ and return to IDLE next cycle.
REQ-023 Simultaneous release conditions SHALL produce exactly one release.
REQ-024 Pending output beat SHALL NOT block release; the FSM may return to IDLE with out_valid=1, and the next grant waits on out_ready through REQ-017.
REQ-025 Requester deasserting in_valid without handshake SHALL lose nothing (no beat captured); arbiter does not enforce AXI-style valid stability.
REQ-026 Payload bits of non-granted requesters SHALL have no effect on any output.

Reset
REQ-027 While rst=0: state=IDLE, rr_ptr=0, grant=0, beat_cnt=0, out_valid=0, out_data=0, out_id=0, in_ready=0, asynchronously.
REQ-028 Reset asserted mid-burst SHALL discard the pending output beat; after release arbitration restarts from requester 0.

Structure
REQ-029 Package stream_arb_pkg SHALL hold the FSM state enum and the ID_W width function.
REQ-030 Rotating priority selection SHALL be a sub-module rr_pick (inputs req vector, rr_ptr; outputs any, idx), purely combinational.
REQ-031 All outputs except in_ready SHALL be driven directly from flops.

Verification
REQ-032 Reset: hold rst=0 with random inputs -> out_valid=0, in_ready=0000, out_id=0; first grant after release goes to requester 0 when all 4 valid.
REQ-033 Round-robin: N_REQ=4, all valid continuously, in_last=0, out_ready=1 -> bursts of 4 beats each, out_id order 0,1,2,3,0, one bubble cycle between bursts.
REQ-034 Last: requester 2 only, in_last high on its 2nd beat -> 2 beats out with out_id=2, then IDLE, rr_ptr=3.
REQ-035 Backpressure: out_ready=0 for 5 cycles mid-burst -> out_data held stable, in_ready[grant]=0, no beat lost or duplicated (scoreboard per requester).
REQ-036 Valid drop: granted requester 1 drops in_valid after 1 beat while requester 3 waits -> release, next grant is requester 3.
REQ-037 Random: random valid/last, out_ready high with 40% probability, driving short_fifo DEPTH=16 -> per-requester in-order, lossless data at FIFO read side.
